// File: rtl/switch_pkg.sv
// Shared constants and arbiter state type for the front-panel switch controller.
package switch_pkg;

  localparam int NSW_DEF  = 4;
  localparam int DIV_DEF  = 1000;
  localparam int HOLD_DEF = 30;
  localparam int ID_W     = $clog2(NSW_DEF);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping at NSW.
module rr_arbiter #(
  parameter int NSW = 4
) (
  input  logic [NSW-1:0]         req,
  input  logic [$clog2(NSW)-1:0] ptr,
  output logic [$clog2(NSW)-1:0] grant,
  output logic                   any
);

  localparam int IW = $clog2(NSW);

  logic [IW:0] idx;

  // Walk from the farthest candidate back to ptr so the nearest hit is written last.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = '0;
    for (int k = NSW - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + (IW + 1)'(k);
      if (idx >= (IW + 1)'(NSW)) begin
        idx = idx - (IW + 1)'(NSW);
      end
      if (req[idx[IW-1:0]]) begin
        grant = idx[IW-1:0];
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/switch_event_controller.sv
// Debounces NSW active-low switches on one shared sample tick and offers press
// events one at a time through a round-robin arbiter.
module switch_event_controller
  import switch_pkg::*;
#(
  parameter int NSW  = NSW_DEF,
  parameter int DIV  = DIV_DEF,
  parameter int HOLD = HOLD_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NSW-1:0]         switchin,
  output logic [NSW-1:0]         pressed,
  output logic                   event_valid,
  output logic [$clog2(NSW)-1:0] event_id,
  input  logic                   event_ack,
  output logic                   overrun,
  output arb_state_e             arb_state
);

  localparam int IW = $clog2(NSW);
  localparam int PW = $clog2(DIV);

  logic [NSW-1:0] sync_meta;
  logic [NSW-1:0] sync_q;
  logic [PW-1:0]  presc;
  logic           tick;
  logic [7:0]     cnt [NSW];
  logic [NSW-1:0] detect;
  logic [NSW-1:0] pending;
  logic [NSW-1:0] clr;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  grant;
  logic           grant_any;
  logic           load_id;
  logic           advance;
  arb_state_e     state;
  arb_state_e     next_state;

  // Idle level of an unpressed switch is high, so the synchronizer resets to ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_meta <= '1;
      sync_q    <= '1;
    end else begin
      sync_meta <= switchin;
      sync_q    <= sync_meta;
    end
  end

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_comb begin
    detect = '0;
    for (int i = 0; i < NSW; i++) begin
      detect[i] = tick && !sync_q[i] && (cnt[i] == 8'(HOLD - 1));
    end
  end

  // Counters saturate at HOLD so a held switch detects exactly once.
  always_ff @(posedge clock) begin
    if (reset) begin
      pressed <= '0;
      for (int i = 0; i < NSW; i++) begin
        cnt[i] <= '0;
      end
    end else if (tick) begin
      for (int i = 0; i < NSW; i++) begin
        if (sync_q[i]) begin
          cnt[i]     <= '0;
          pressed[i] <= 1'b0;
        end else begin
          if (cnt[i] != 8'(HOLD)) begin
            cnt[i] <= cnt[i] + 8'd1;
          end
          if (detect[i]) begin
            pressed[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    clr = '0;
    if (event_valid && event_ack) begin
      clr[event_id] = 1'b1;
    end
  end

  // A detect on the same edge as its own ack re-arms the bit without flagging overrun.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | detect;
      if (|(detect & pending & ~clr)) begin
        overrun <= 1'b1;
      end
    end
  end

  rr_arbiter #(
    .NSW (NSW)
  ) u_rr_arbiter (
    .req   (pending),
    .ptr   (rr_ptr),
    .grant (grant),
    .any   (grant_any)
  );

  // Handshake: an event transfers on a rising edge where event_valid and event_ack
  // are both 1; event_id is stable while event_valid is 1, and event_valid stays
  // low for at least one cycle after every transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    load_id    = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          load_id    = 1'b1;
          next_state = OFFER;
        end
      end
      OFFER: begin
        if (event_ack) begin
          advance    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      event_id <= '0;
      rr_ptr   <= '0;
    end else begin
      if (load_id) begin
        event_id <= grant;
      end
      if (advance) begin
        rr_ptr <= (event_id == IW'(NSW - 1)) ? '0 : event_id + 1'b1;
      end
    end
  end

  assign event_valid = (state == OFFER);
  assign arb_state   = state;

endmodule

// File: tb/tb_switch_event_controller.sv
// Scoreboard bench for switch_event_controller with NSW=4, DIV=4, HOLD=3.
module tb_switch_event_controller;
  import switch_pkg::*;

  localparam int NSW  = 4;
  localparam int DIV  = 4;
  localparam int HOLD = 3;
  localparam int IW   = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NSW-1:0] switchin = '1;
  logic [NSW-1:0] pressed;
  logic           event_valid;
  logic [IW-1:0]  event_id;
  logic           event_ack = 1'b0;
  logic           overrun;
  arb_state_e     arb_state;

  int checks = 0;
  int errors = 0;
  logic [IW-1:0] exp_q[$];

  switch_event_controller #(
    .NSW  (NSW),
    .DIV  (DIV),
    .HOLD (HOLD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .switchin    (switchin),
    .pressed     (pressed),
    .event_valid (event_valid),
    .event_id    (event_id),
    .event_ack   (event_ack),
    .overrun     (overrun),
    .arb_state   (arb_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge, outputs are sampled there too
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic release_all();
    switchin = '1;
    cycles(4 * DIV);
  endtask

  task automatic wait_pressed(input int idx, input int max, output int n);
    n = 0;
    while (!pressed[idx] && n < max) begin
      @(negedge clock);
      n++;
    end
    check($sformatf("pressed_rise_%0d", idx), 32'(pressed[idx]), 32'd1);
  endtask

  // Waits for an offer, scores event_id against the queue head, then acks it.
  task automatic accept(input int max);
    int n = 0;
    logic [IW-1:0] exp_id;
    while (!event_valid && n < max) begin
      @(negedge clock);
      n++;
    end
    check("event_offered", 32'(event_valid), 32'd1);
    if (event_valid) begin
      check("sb_has_entry", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_id = exp_q.pop_front();
        check("event_id", 32'(event_id), 32'(exp_id));
      end
      event_ack = 1'b1;
      @(negedge clock);
      event_ack = 1'b0;
      check("valid_drop_after_ack", 32'(event_valid), 32'd0);
    end
  endtask

  task automatic expect_quiet(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clock);
      if (event_valid) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    int n;

    // reset state
    reset = 1'b1;
    switchin = '1;
    cycles(2);
    check("reset_pressed", 32'(pressed), 32'd0);
    check("reset_valid", 32'(event_valid), 32'd0);
    check("reset_id", 32'(event_id), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    expect_quiet("idle_no_event", 100);
    check("idle_pressed", 32'(pressed), 32'd0);

    // clean press on switch 1: 2 sync edges, then 3 ticks (first tick within 4 edges)
    switchin[1] = 1'b0;
    wait_pressed(1, 40, n);
    check("clean_latency", 32'(n >= 11 && n <= 14), 32'd1);
    check("clean_pressed_vec", 32'(pressed), 32'b0010);
    check("valid_lags_detect", 32'(event_valid), 32'd0);
    exp_q.push_back(2'd1);
    @(negedge clock);
    check("valid_next_cycle", 32'(event_valid), 32'd1);
    accept(5);
    expect_quiet("held_no_repeat", 50);
    check("held_level", 32'(pressed[1]), 32'd1);
    release_all();
    check("release_level", 32'(pressed), 32'd0);

    // bounce on switch 2: low 2 ticks, high 1 tick, then held low
    switchin[2] = 1'b0;
    cycles(2 * DIV);
    switchin[2] = 1'b1;
    cycles(DIV);
    check("bounce_no_early_press", 32'(pressed[2]), 32'd0);
    check("bounce_no_early_event", 32'(event_valid), 32'd0);
    switchin[2] = 1'b0;
    wait_pressed(2, 40, n);
    check("bounce_restart_latency", 32'(n >= 11 && n <= 14), 32'd1);
    exp_q.push_back(2'd2);
    accept(5);
    expect_quiet("bounce_single_event", 30);
    release_all();

    // round robin from a fresh pointer, then from pointer 2 after an event on switch 1
    pulse_reset();
    switchin = 4'b0110;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    wait_pressed(0, 40, n);
    check("rr_same_tick", 32'(pressed), 32'b1001);
    accept(5);
    accept(5);
    release_all();
    switchin = 4'b1101;
    exp_q.push_back(2'd1);
    accept(40);
    release_all();
    switchin = 4'b0110;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    accept(40);
    accept(5);
    release_all();

    // overrun: re-press switch 0 while its first event is still offered
    pulse_reset();
    switchin = 4'b1110;
    exp_q.push_back(2'd0);
    wait_pressed(0, 40, n);
    @(negedge clock);
    check("ovr_first_valid", 32'(event_valid), 32'd1);
    check("ovr_first_flag", 32'(overrun), 32'd0);
    switchin = '1;
    cycles(4 * DIV);
    check("ovr_released", 32'(pressed[0]), 32'd0);
    switchin = 4'b1110;
    wait_pressed(0, 40, n);
    check("ovr_flag_set", 32'(overrun), 32'd1);
    check("ovr_id_held", 32'(event_id), 32'd0);
    cycles(10);
    check("ovr_sticky", 32'(overrun), 32'd1);
    accept(5);
    expect_quiet("ovr_one_pending", 40);
    check("ovr_sticky_after_ack", 32'(overrun), 32'd1);
    release_all();

    // reset while an event is offered: it is dropped, nothing follows
    switchin = 4'b1011;
    wait_pressed(2, 40, n);
    @(negedge clock);
    check("mid_offer_valid", 32'(event_valid), 32'd1);
    switchin = '1;
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_valid", 32'(event_valid), 32'd0);
    check("mid_reset_pressed", 32'(pressed), 32'd0);
    check("mid_reset_overrun", 32'(overrun), 32'd0);
    check("mid_reset_id", 32'(event_id), 32'd0);
    reset = 1'b0;
    expect_quiet("post_reset_quiet", 60);

    // report
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
